// File: rtl/shiftreg_seq_ctrl.sv
// shiftreg_seq_ctrl: transaction sequencer for the enhanced 4-bit shift register.
// Each accepted command parallel-loads a nibble, then runs COUNT shift/rotate
// cycles, feeding S_IN from SIN_WORD and capturing every S_OUT bit. When the
// command finishes, it returns the final Q with a one-cycle DONE pulse.
// Optional feature macro: SHIFTREG_SEQ_ABORT_EN adds the ABORT input and the
// ABORTED output.

module shiftreg_seq_ctrl #(
  parameter int CW = 3,
  parameter int W  = 2**CW
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [1:0]    OP,
  input  logic          DIR_REQ,
  input  logic [3:0]    DATA_IN,
  input  logic [W-1:0]  SIN_WORD,
  input  logic [CW-1:0] COUNT,
  output logic          READY,
  output logic          DONE,
  output logic          ERR,
  output logic [W-1:0]  CAPTURE,
  output logic [3:0]    Q_FINAL,
  output logic          ENB,
  output logic          DIR,
  output logic          S_IN,
  output logic [1:0]    MODO,
  output logic [3:0]    D,
  input  logic [3:0]    Q,
  input  logic          S_OUT
`ifdef SHIFTREG_SEQ_ABORT_EN
  ,
  input  logic          ABORT,
  output logic          ABORTED
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t state_r, state_next_s;

  // Command fields latched on accept
  logic          op_rot_r;
  logic          dir_lat_r;
  logic [W-1:0]  word_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] idx_r;

  // Registered outputs
  logic [W-1:0]  capture_r;
  logic [3:0]    q_final_r;
  logic          done_r, err_r, ready_r;
  logic          enb_r, dir_r, s_in_r;
  logic [1:0]    modo_r;
  logic [3:0]    d_r;

  // Next values for the shift register controls
  logic          enb_next_s, dir_next_s, s_in_next_s;
  logic [1:0]    modo_next_s;
  logic [3:0]    d_next_s;
  logic [CW-1:0] sin_idx_s;
  logic [CW-1:0] last_idx_s;

  logic          accept_s, illegal_s, abort_s;

  assign accept_s   = (state_r == S_IDLE) && START && !OP[1];
  assign illegal_s  = (state_r == S_IDLE) && START && OP[1];
  assign last_idx_s = count_r - CW'(1);

`ifdef SHIFTREG_SEQ_ABORT_EN
  assign abort_s = ABORT && ((state_r == S_LOAD) || (state_r == S_SHIFT));
`else
  assign abort_s = 1'b0;
`endif

  // Next-state logic for the IDLE/LOAD/SHIFT/FIN sequencer
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_next_s = S_LOAD;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort_s) begin
          state_next_s = S_FIN;
        end else if (count_r != {CW{1'b0}}) begin
          state_next_s = S_SHIFT;
        end else begin
          state_next_s = S_FIN;
        end
      end
      S_SHIFT: begin
        if (abort_s) begin
          state_next_s = S_FIN;
        end else if (idx_r == last_idx_s) begin
          state_next_s = S_FIN;
        end else begin
          state_next_s = S_SHIFT;
        end
      end
      S_FIN: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Decode the shift register controls for the cycle being entered
  always_comb begin
    enb_next_s  = 1'b0;
    modo_next_s = 2'b00;
    dir_next_s  = 1'b0;
    s_in_next_s = 1'b0;
    d_next_s    = 4'b0000;
    // Serial bit for the upcoming shift: index 0 on entry, else the next index
    if (state_r == S_SHIFT) begin
      sin_idx_s = idx_r + CW'(1);
    end else begin
      sin_idx_s = {CW{1'b0}};
    end
    case (state_next_s)
      S_LOAD: begin
        enb_next_s  = 1'b1;
        modo_next_s = 2'b10;
        d_next_s    = DATA_IN;
      end
      S_SHIFT: begin
        enb_next_s  = 1'b1;
        modo_next_s = {1'b0, op_rot_r};
        dir_next_s  = dir_lat_r;
        s_in_next_s = word_r[sin_idx_s];
      end
      default: begin
        enb_next_s  = 1'b0;
      end
    endcase
  end

  // State register, handshake pulses and registered shift register controls
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= S_IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      enb_r   <= 1'b0;
      modo_r  <= 2'b00;
      dir_r   <= 1'b0;
      s_in_r  <= 1'b0;
      d_r     <= 4'b0000;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == S_IDLE);
      done_r  <= (state_r == S_FIN);
      err_r   <= illegal_s;
      enb_r   <= enb_next_s;
      modo_r  <= modo_next_s;
      dir_r   <= dir_next_s;
      s_in_r  <= s_in_next_s;
      d_r     <= d_next_s;
    end
  end

  // Command latch, shift index, serial capture and final Q snapshot
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_rot_r  <= 1'b0;
      dir_lat_r <= 1'b0;
      word_r    <= {W{1'b0}};
      count_r   <= {CW{1'b0}};
      idx_r     <= {CW{1'b0}};
      capture_r <= {W{1'b0}};
      q_final_r <= 4'b0000;
    end else begin
      if (accept_s) begin
        op_rot_r  <= OP[0];
        dir_lat_r <= DIR_REQ;
        word_r    <= SIN_WORD;
        count_r   <= COUNT;
      end
      case (state_r)
        S_LOAD: begin
          capture_r <= {W{1'b0}};
          idx_r     <= {CW{1'b0}};
        end
        S_SHIFT: begin
          // An aborted cycle has ENB low, so nothing moved and nothing is captured
          if (!abort_s) begin
            capture_r[idx_r] <= S_OUT;
            idx_r            <= idx_r + CW'(1);
          end
        end
        S_FIN: begin
          q_final_r <= Q;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SHIFTREG_SEQ_ABORT_EN
  logic aborted_pend_r;
  logic aborted_r;

  // Remember an abort until FIN, then pulse ABORTED alongside DONE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      aborted_pend_r <= 1'b0;
      aborted_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        aborted_pend_r <= 1'b0;
      end else if (abort_s) begin
        aborted_pend_r <= 1'b1;
      end
      aborted_r <= (state_r == S_FIN) && aborted_pend_r;
    end
  end

  assign ABORTED = aborted_r;
`endif

  // ENB drops in the same cycle as ABORT; abort_s is tied low otherwise
  assign ENB     = enb_r & ~abort_s;
  assign MODO    = modo_r;
  assign DIR     = dir_r;
  assign S_IN    = s_in_r;
  assign D       = d_r;
  assign READY   = ready_r;
  assign DONE    = done_r;
  assign ERR     = err_r;
  assign CAPTURE = capture_r;
  assign Q_FINAL = q_final_r;

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Testbench for shiftreg_seq_ctrl: a behavioural 4-bit shift register closes the
// loop, stimulus pushes hand-computed results into a scoreboard, and a monitor
// pops and compares whenever DONE or ERR appears.

module tb_shiftreg_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RESET, START, DIR_REQ;
  logic [1:0] OP;
  logic [3:0] DATA_IN;
  logic [7:0] SIN_WORD;
  logic [2:0] COUNT;
  logic       READY, DONE, ERR;
  logic [7:0] CAPTURE;
  logic [3:0] Q_FINAL;
  logic       ENB, DIR, S_IN;
  logic [1:0] MODO;
  logic [3:0] D, Q;
  logic       S_OUT;
`ifdef SHIFTREG_SEQ_ABORT_EN
  logic       ABORT = 1'b0;
  logic       ABORTED;
`endif

  shiftreg_seq_ctrl dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .DIR_REQ(DIR_REQ),
    .DATA_IN(DATA_IN), .SIN_WORD(SIN_WORD), .COUNT(COUNT),
    .READY(READY), .DONE(DONE), .ERR(ERR), .CAPTURE(CAPTURE), .Q_FINAL(Q_FINAL),
    .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO), .D(D), .Q(Q), .S_OUT(S_OUT)
`ifdef SHIFTREG_SEQ_ABORT_EN
    , .ABORT(ABORT), .ABORTED(ABORTED)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural shift register driven by the sequencer
  logic [3:0] sr_q = 4'b0000;
  always @(posedge CLK) begin
    if (ENB) begin
      case (MODO)
        2'b00:   sr_q <= DIR ? {S_IN, sr_q[3:1]} : {sr_q[2:0], S_IN};
        2'b01:   sr_q <= DIR ? {sr_q[0], sr_q[3:1]} : {sr_q[2:0], sr_q[3]};
        2'b10:   sr_q <= D;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign Q     = sr_q;
  assign S_OUT = DIR ? sr_q[0] : sr_q[3];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       is_err;
    int         cyc;
    logic [7:0] cap;
    logic [3:0] qf;
    logic       ab;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic dir, input logic [3:0] data,
                       input logic [7:0] word, input logic [2:0] cnt,
                       input logic [7:0] ecap, input logic [3:0] eqf, input logic push);
    exp_t e;
    chk("ready_before_start", 32'(READY), 32'd1);
    OP = op; DIR_REQ = dir; DATA_IN = data; SIN_WORD = word; COUNT = cnt; START = 1'b1;
    if (push) begin
      e.is_err = op[1];
      e.cyc    = op[1] ? cyc + 1 : cyc + 3 + int'(cnt);
      e.cap    = ecap;
      e.qf     = eqf;
      e.ab     = 1'b0;
      sb.push_back(e);
    end
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      chk("completion_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    int   c;
    exp_t e;
    RESET = 1'b1; START = 1'b0; OP = 2'b00; DIR_REQ = 1'b0;
    DATA_IN = 4'b0000; SIN_WORD = 8'h00; COUNT = 3'd0;

    fork
      begin : monitor
        exp_t m;
        forever begin
          @(negedge CLK);
          if (DONE === 1'b1 || ERR === 1'b1) begin
            if (sb.size() == 0) begin
              chk("unexpected_done_err", {30'd0, DONE, ERR}, 32'd0);
            end else begin
              m = sb.pop_front();
              chk("err_flag", 32'(ERR), 32'(m.is_err));
              chk("done_flag", 32'(DONE), 32'(!m.is_err));
              chk("response_cycle", 32'(cyc), 32'(m.cyc));
              if (!m.is_err) begin
                chk("capture", 32'(CAPTURE), 32'(m.cap));
                chk("q_final", 32'(Q_FINAL), 32'(m.qf));
`ifdef SHIFTREG_SEQ_ABORT_EN
                chk("aborted", 32'(ABORTED), 32'(m.ab));
`endif
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_ready", 32'(READY), 32'd1);
    chk("rst_enb", 32'(ENB), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_capture", 32'(CAPTURE), 32'd0);
    chk("rst_q_final", 32'(Q_FINAL), 32'd0);
    chk("rst_modo", 32'(MODO), 32'd0);
    chk("rst_d", 32'(D), 32'd0);

    // Left shift, COUNT=3: Q 0111,1110,1101; S_OUT 1,0,1
    issue(2'b00, 1'b0, 4'b1011, 8'b0000_0101, 3'd3, 8'b0000_0101, 4'b1101, 1'b1);
    wait_idle(30);
    // Right rotate, COUNT=4: Q 1000,0100,0010,0001; S_OUT 1,0,0,0; SIN ignored
    issue(2'b01, 1'b1, 4'b0001, 8'hFF, 3'd4, 8'b0000_0001, 4'b0001, 1'b1);
    wait_idle(30);
    // COUNT=0: load only
    issue(2'b00, 1'b0, 4'b1010, 8'hFF, 3'd0, 8'h00, 4'b1010, 1'b1);
    wait_idle(30);
    // Max count, left rotate by 7 of 1001 -> 1100; S_OUT 1,0,0,1,1,0,0
    issue(2'b01, 1'b0, 4'b1001, 8'h00, 3'd7, 8'b0001_1001, 4'b1100, 1'b1);
    wait_idle(30);

    // Illegal OP: ERR one cycle later, still ready, never enabled
    issue(2'b10, 1'b0, 4'b1111, 8'hFF, 3'd2, 8'h00, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("err_ready", 32'(READY), 32'd1);
      chk("err_enb", 32'(ENB), 32'd0);
      @(negedge CLK);
    end
    wait_idle(10);

    // Reset on the second SHIFT cycle of COUNT=5 aborts silently
    c = cyc;
    issue(2'b00, 1'b0, 4'b1111, 8'h00, 3'd5, 8'h00, 4'h0, 1'b0);
    while (cyc < c + 3) @(negedge CLK);
    chk("mid_enb_before_reset", 32'(ENB), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("midrst_enb", 32'(ENB), 32'd0);
    chk("midrst_ready", 32'(READY), 32'd1);
    chk("midrst_capture", 32'(CAPTURE), 32'd0);
    chk("midrst_q_final", 32'(Q_FINAL), 32'd0);
    repeat (12) @(negedge CLK);

    // RESET wins over START on the same edge
    RESET = 1'b1; START = 1'b1; OP = 2'b00; COUNT = 3'd1;
    @(negedge CLK);
    RESET = 1'b0; START = 1'b0;
    chk("prio_ready", 32'(READY), 32'd1);
    chk("prio_enb", 32'(ENB), 32'd0);
    repeat (6) @(negedge CLK);

    // START held through DONE: second command loads right after DONE
    c = cyc;
    OP = 2'b00; DIR_REQ = 1'b0; DATA_IN = 4'b0110; SIN_WORD = 8'b0000_0010; COUNT = 3'd2;
    START = 1'b1;
    e.is_err = 1'b0; e.cyc = c + 5; e.cap = 8'b0000_0010; e.qf = 4'b1001; e.ab = 1'b0;
    sb.push_back(e);
    @(negedge CLK);
    OP = 2'b00; DIR_REQ = 1'b1; DATA_IN = 4'b1100; SIN_WORD = 8'b0000_0110; COUNT = 3'd3;
    e.is_err = 1'b0; e.cyc = c + 11; e.cap = 8'b0000_0100; e.qf = 4'b1101; e.ab = 1'b0;
    sb.push_back(e);
    while (cyc < c + 6) @(negedge CLK);
    chk("b2b_ready", 32'(READY), 32'd0);
    chk("b2b_enb", 32'(ENB), 32'd1);
    chk("b2b_modo", 32'(MODO), 32'd2);
    chk("b2b_d", 32'(D), 32'(4'b1100));
    START = 1'b0;
    wait_idle(40);

`ifdef SHIFTREG_SEQ_ABORT_EN
    // ABORT on shift index 1 of COUNT=4: only CAPTURE[0] written, Q=0110
    c = cyc;
    issue(2'b00, 1'b0, 4'b1011, 8'h00, 3'd4, 8'h00, 4'h0, 1'b0);
    e.is_err = 1'b0; e.cyc = c + 5; e.cap = 8'b0000_0001; e.qf = 4'b0110; e.ab = 1'b1;
    sb.push_back(e);
    while (cyc < c + 3) @(negedge CLK);
    ABORT = 1'b1;
    #1;
    chk("abort_enb", 32'(ENB), 32'd0);
    @(negedge CLK);
    ABORT = 1'b0;
    wait_idle(30);
`endif

    repeat (4) @(negedge CLK);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
